// File: rtl/dpram_pkg.sv
// Shared types and default geometry for the dual-port RAM and its response pipelines.
package dpram_pkg;

    localparam int DPRAM_BYTE_WIDTH = 8;
    localparam int DPRAM_DATA_WIDTH = 32;
    localparam int DPRAM_ADDR_WIDTH = 32;
    localparam int DPRAM_SRAM_DEPTH = 1024;

    // One response beat; rdata is sized by the package data width.
    typedef struct packed {
        logic [DPRAM_DATA_WIDTH-1:0] rdata;
        logic                        err;
    } dpram_rsp_t;

endpackage

// File: rtl/dpram_rsp_pipe.sv
// One port's response pipeline: stage 1 sits behind the RAM read register,
// optional stage 2 is the OUT_REG output register.
module dpram_rsp_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
    parameter int OUT_REG    = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_ce,
    input  logic                  i_oor,
    input  logic [DATA_WIDTH-1:0] i_s1_rdata,
    input  logic                  i_s1_par_err,
    input  logic                  i_rready,
    output logic                  o_ready,
    output logic                  o_accept,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_err
);

    // Handshakes: a request moves on a rising edge where i_ce && o_ready;
    // a response moves on a rising edge where o_valid && i_rready, and
    // o_valid/o_rdata/o_err hold unchanged until that edge.

    logic       rdy_q;
    logic       v1_q;
    logic       oor1_q;
    logic       adv1;
    logic       out_valid;
    dpram_rsp_t s1_rsp;
    dpram_rsp_t out_rsp;

    always_comb begin
        s1_rsp.rdata = oor1_q ? '0 : i_s1_rdata;
        s1_rsp.err   = oor1_q | i_s1_par_err;
    end

    // Keeps READY low through reset and on the edge where reset releases.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign o_ready  = rdy_q && (!v1_q || adv1);
    assign o_accept = i_ce && o_ready;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            v1_q   <= 1'b0;
            oor1_q <= 1'b0;
        end else if (o_accept) begin
            v1_q   <= 1'b1;
            oor1_q <= i_oor;
        end else if (adv1) begin
            v1_q   <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic       v2_q;
            dpram_rsp_t s2_q;

            assign adv1 = v1_q && (!v2_q || i_rready);

            always_ff @(posedge i_CLK or negedge i_RSTn) begin
                if (!i_RSTn) begin
                    v2_q <= 1'b0;
                    s2_q <= '0;
                end else if (adv1) begin
                    v2_q <= 1'b1;
                    s2_q <= s1_rsp;
                end else if (i_rready) begin
                    v2_q <= 1'b0;
                end
            end

            assign out_valid = v2_q;
            assign out_rsp   = s2_q;
        end else begin : g_no_out_reg
            assign adv1      = v1_q && i_rready;
            assign out_valid = v1_q;
            assign out_rsp   = s1_rsp;
        end
    endgenerate

    // Outputs read as zero whenever no response is pending.
    assign o_valid = out_valid;
    assign o_rdata = out_valid ? out_rsp.rdata : '0;
    assign o_err   = out_valid & out_rsp.err;

endmodule

// File: rtl/dpram.sv
// True dual-port RAM with byte enables, read-first, and independent response pipelines.
// Defining DPRAM_PARITY_EN adds one even-parity bit per byte lane, reported through o_P_ERR.
module dpram
    import dpram_pkg::*;
#(
    parameter int BYTE_WIDTH = DPRAM_BYTE_WIDTH,
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
    parameter int SRAM_DEPTH = DPRAM_SRAM_DEPTH,
    parameter int OUT_REG    = 0,
    localparam int N_COLS    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_A_CE,
    output logic                  o_A_READY,
    input  logic [N_COLS-1:0]     i_A_WE,
    input  logic [ADDR_WIDTH-1:0] i_A_ADDR,
    input  logic [DATA_WIDTH-1:0] i_A_WDATA,
    output logic [DATA_WIDTH-1:0] o_A_RDATA,
    output logic                  o_A_VALID,
    input  logic                  i_A_RREADY,
    output logic                  o_A_ERR,
    input  logic                  i_B_CE,
    output logic                  o_B_READY,
    input  logic [N_COLS-1:0]     i_B_WE,
    input  logic [ADDR_WIDTH-1:0] i_B_ADDR,
    input  logic [DATA_WIDTH-1:0] i_B_WDATA,
    output logic [DATA_WIDTH-1:0] o_B_RDATA,
    output logic                  o_B_VALID,
    input  logic                  i_B_RREADY,
    output logic                  o_B_ERR
);

    localparam int IDX_W = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

    logic                  a_accept;
    logic                  b_accept;
    logic                  a_in_rng;
    logic                  b_in_rng;
    logic                  a_oor;
    logic                  b_oor;
    logic [IDX_W-1:0]      a_idx;
    logic [IDX_W-1:0]      b_idx;
    logic [DATA_WIDTH-1:0] a_rd_q;
    logic [DATA_WIDTH-1:0] b_rd_q;
    logic                  a_par_err;
    logic                  b_par_err;

    assign a_in_rng = i_A_ADDR < ADDR_WIDTH'(SRAM_DEPTH);
    assign b_in_rng = i_B_ADDR < ADDR_WIDTH'(SRAM_DEPTH);
    assign a_oor    = !a_in_rng;
    assign b_oor    = !b_in_rng;
    assign a_idx    = i_A_ADDR[IDX_W-1:0];
    assign b_idx    = i_B_ADDR[IDX_W-1:0];

    // Non-blocking reads see pre-edge contents; port A's lane writes are
    // scheduled after port B's, so A wins on lanes both ports enable.
    always_ff @(posedge i_CLK) begin
        if (a_accept) begin
            a_rd_q <= mem[a_idx];
        end
        if (b_accept) begin
            b_rd_q <= mem[b_idx];
        end
        for (int c = 0; c < N_COLS; c++) begin
            if (b_accept && b_in_rng && i_B_WE[c]) begin
                mem[b_idx][c*BYTE_WIDTH +: BYTE_WIDTH] <= i_B_WDATA[c*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (a_accept && a_in_rng && i_A_WE[c]) begin
                mem[a_idx][c*BYTE_WIDTH +: BYTE_WIDTH] <= i_A_WDATA[c*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [N_COLS-1:0] par [SRAM_DEPTH];
    logic [N_COLS-1:0] a_rp_q;
    logic [N_COLS-1:0] b_rp_q;

    always_ff @(posedge i_CLK) begin
        if (a_accept) begin
            a_rp_q <= par[a_idx];
        end
        if (b_accept) begin
            b_rp_q <= par[b_idx];
        end
        for (int c = 0; c < N_COLS; c++) begin
            if (b_accept && b_in_rng && i_B_WE[c]) begin
                par[b_idx][c] <= ^i_B_WDATA[c*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (a_accept && a_in_rng && i_A_WE[c]) begin
                par[a_idx][c] <= ^i_A_WDATA[c*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        a_par_err = 1'b0;
        b_par_err = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            if (a_rp_q[c] != ^a_rd_q[c*BYTE_WIDTH +: BYTE_WIDTH]) begin
                a_par_err = 1'b1;
            end
            if (b_rp_q[c] != ^b_rd_q[c*BYTE_WIDTH +: BYTE_WIDTH]) begin
                b_par_err = 1'b1;
            end
        end
    end
`else
    assign a_par_err = 1'b0;
    assign b_par_err = 1'b0;
`endif

    dpram_rsp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_a (
        .i_CLK        (i_CLK),
        .i_RSTn       (i_RSTn),
        .i_ce         (i_A_CE),
        .i_oor        (a_oor),
        .i_s1_rdata   (a_rd_q),
        .i_s1_par_err (a_par_err),
        .i_rready     (i_A_RREADY),
        .o_ready      (o_A_READY),
        .o_accept     (a_accept),
        .o_valid      (o_A_VALID),
        .o_rdata      (o_A_RDATA),
        .o_err        (o_A_ERR)
    );

    dpram_rsp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_b (
        .i_CLK        (i_CLK),
        .i_RSTn       (i_RSTn),
        .i_ce         (i_B_CE),
        .i_oor        (b_oor),
        .i_s1_rdata   (b_rd_q),
        .i_s1_par_err (b_par_err),
        .i_rready     (i_B_RREADY),
        .o_ready      (o_B_READY),
        .o_accept     (b_accept),
        .o_valid      (o_B_VALID),
        .o_rdata      (o_B_RDATA),
        .o_err        (o_B_ERR)
    );

endmodule
